// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock sample FIFO.
// Depth helper, read-mode encodings and the status flag bundle.
package sync_fifo_pkg;

    localparam bit FWFT_STD = 1'b0;
    localparam bit FWFT_ON  = 1'b1;

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
    } fifo_flags_t;

    function automatic int fifo_depth(input int addr_size);
        return 1 << addr_size;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Dual-port storage array for the sample FIFO.
// Registered write port, asynchronous read port, contents never reset.
module sync_fifo_ram #(
    parameter int DATA_SIZE = 4,
    parameter int ADDR_SIZE = 2
) (
    input  logic                 clk_i,
    input  logic                 w_en_i,
    input  logic [ADDR_SIZE-1:0] w_addr_i,
    input  logic [DATA_SIZE-1:0] w_data_i,
    input  logic [ADDR_SIZE-1:0] r_addr_i,
    output logic [DATA_SIZE-1:0] r_data_o
);

    logic [DATA_SIZE-1:0] mem [1 << ADDR_SIZE];

    always_ff @(posedge clk_i) begin
        if (w_en_i) begin
            mem[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock sample FIFO with fill level, thresholds, sticky errors,
// synchronous flush and standard or first-word-fall-through read mode.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_SIZE     = 4,
    parameter int ADDR_SIZE     = 2,
    parameter int AFULL_THRESH  = 3,
    parameter int AEMPTY_THRESH = 1,
    parameter bit FWFT          = FWFT_STD
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 w_inc_i,
    input  logic [DATA_SIZE-1:0] w_data_i,
    input  logic                 r_inc_i,
    output logic [DATA_SIZE-1:0] r_data_o,
    output logic                 r_valid_o,
    output logic                 fifo_full_o,
    output logic                 fifo_empty_o,
    output logic                 almost_full_o,
    output logic                 almost_empty_o,
    output logic [ADDR_SIZE:0]   level_o,
    output logic                 overflow_o,
    output logic                 underflow_o
);

    localparam int LW = ADDR_SIZE + 1;
    localparam logic [LW-1:0] DEPTH_LVL = LW'(fifo_depth(ADDR_SIZE));
    localparam logic [LW-1:0] AF_LVL    = LW'(AFULL_THRESH);
    localparam logic [LW-1:0] AE_LVL    = LW'(AEMPTY_THRESH);

    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic [LW-1:0]        level;
    logic                 ovf;
    logic                 udf;
    logic                 w_acc;
    logic                 r_acc;
    logic                 ram_we;
    logic [DATA_SIZE-1:0] ram_rdata;
    fifo_flags_t          flags;

    always_comb begin
        flags        = '0;
        flags.full   = (level == DEPTH_LVL);
        flags.empty  = (level == '0);
        flags.afull  = (level >= AF_LVL);
        flags.aempty = (level <= AE_LVL);
    end

    // Acceptance looks only at registered state, never at the other request.
    assign w_acc  = w_inc_i & ~flags.full;
    assign r_acc  = r_inc_i & ~flags.empty;
    assign ram_we = w_acc & rst_i & ~clr_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else if (clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (w_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (r_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case (1'b1)
                w_acc & ~r_acc: level <= level + 1'b1;
                r_acc & ~w_acc: level <= level - 1'b1;
                default: ;
            endcase
            if (w_inc_i & flags.full) begin
                ovf <= 1'b1;
            end
            if (r_inc_i & flags.empty) begin
                udf <= 1'b1;
            end
        end
    end

    sync_fifo_ram #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_ram (
        .clk_i    (clk_i),
        .w_en_i   (ram_we),
        .w_addr_i (wr_ptr),
        .w_data_i (w_data_i),
        .r_addr_i (rd_ptr),
        .r_data_o (ram_rdata)
    );

    generate
        if (FWFT == FWFT_ON) begin : g_fwft
            assign r_data_o  = ram_rdata;
            assign r_valid_o = ~flags.empty;
        end else begin : g_std
            logic [DATA_SIZE-1:0] rdata_q;
            logic                 rvalid_q;

            // Flush drops the valid strobe but keeps the last word visible.
            always_ff @(posedge clk_i) begin
                if (!rst_i) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else if (clr_i) begin
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= r_acc;
                    if (r_acc) begin
                        rdata_q <= ram_rdata;
                    end
                end
            end

            assign r_data_o  = rdata_q;
            assign r_valid_o = rvalid_q;
        end
    endgenerate

    assign fifo_full_o    = flags.full;
    assign fifo_empty_o   = flags.empty;
    assign almost_full_o  = flags.afull;
    assign almost_empty_o = flags.aempty;
    assign level_o        = level;
    assign overflow_o     = ovf;
    assign underflow_o    = udf;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: standard and FWFT instances share stimulus,
// checked against a queue model through a scoreboard.
module tb_sync_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       w_inc;
    logic [3:0] w_data;
    logic       r_inc;

    logic [3:0] rd0, rd1;
    logic       rv0, rv1;
    logic       full0, full1, empty0, empty1;
    logic       af0, af1, ae0, ae1;
    logic [2:0] lvl0, lvl1;
    logic       ovf0, ovf1, udf0, udf1;

    int checks   = 0;
    int failures = 0;

    logic [3:0] mq[$];
    logic [3:0] q0[$];
    logic [3:0] q1[$];
    bit         m_ovf, m_udf, m_rv0;
    logic [3:0] m_rd0;

    always #5 clk = ~clk;

    sync_fifo #(
        .DATA_SIZE(4), .ADDR_SIZE(2), .AFULL_THRESH(3),
        .AEMPTY_THRESH(1), .FWFT(1'b0)
    ) u_std (
        .clk_i(clk), .rst_i(rst_n), .clr_i(clr),
        .w_inc_i(w_inc), .w_data_i(w_data), .r_inc_i(r_inc),
        .r_data_o(rd0), .r_valid_o(rv0),
        .fifo_full_o(full0), .fifo_empty_o(empty0),
        .almost_full_o(af0), .almost_empty_o(ae0),
        .level_o(lvl0), .overflow_o(ovf0), .underflow_o(udf0)
    );

    sync_fifo #(
        .DATA_SIZE(4), .ADDR_SIZE(2), .AFULL_THRESH(3),
        .AEMPTY_THRESH(1), .FWFT(1'b1)
    ) u_fwft (
        .clk_i(clk), .rst_i(rst_n), .clr_i(clr),
        .w_inc_i(w_inc), .w_data_i(w_data), .r_inc_i(r_inc),
        .r_data_o(rd1), .r_valid_o(rv1),
        .fifo_full_o(full1), .fifo_empty_o(empty1),
        .almost_full_o(af1), .almost_empty_o(ae1),
        .level_o(lvl1), .overflow_o(ovf1), .underflow_o(udf1)
    );

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        int lv;
        lv = mq.size();
        chk("level_std", 8'(lvl0), 8'(lv));
        chk("level_fwft", 8'(lvl1), 8'(lv));
        chk("full_std", 8'(full0), 8'(lv == DEPTH));
        chk("full_fwft", 8'(full1), 8'(lv == DEPTH));
        chk("empty_std", 8'(empty0), 8'(lv == 0));
        chk("empty_fwft", 8'(empty1), 8'(lv == 0));
        chk("afull_std", 8'(af0), 8'(lv >= 3));
        chk("afull_fwft", 8'(af1), 8'(lv >= 3));
        chk("aempty_std", 8'(ae0), 8'(lv <= 1));
        chk("aempty_fwft", 8'(ae1), 8'(lv <= 1));
        chk("ovf_std", 8'(ovf0), 8'(m_ovf));
        chk("ovf_fwft", 8'(ovf1), 8'(m_ovf));
        chk("udf_std", 8'(udf0), 8'(m_udf));
        chk("udf_fwft", 8'(udf1), 8'(m_udf));
        chk("rvalid_std", 8'(rv0), 8'(m_rv0));
        chk("rdata_hold_std", 8'(rd0), 8'(m_rd0));
        chk("rvalid_fwft", 8'(rv1), 8'(lv != 0));
    endtask

    // Apply one cycle of inputs; the model predicts the post-edge state.
    task automatic step(input logic rst, input logic c, input logic w,
                        input logic r, input logic [3:0] d);
        logic [3:0] head;
        bit wacc, racc;
        rst_n  = rst;
        clr    = c;
        w_inc  = w;
        r_inc  = r;
        w_data = d;
        if (!rst) begin
            mq.delete();
            m_ovf = 0;
            m_udf = 0;
            m_rv0 = 0;
            m_rd0 = '0;
        end else if (c) begin
            mq.delete();
            m_ovf = 0;
            m_udf = 0;
            m_rv0 = 0;
        end else begin
            wacc = w && (mq.size() < DEPTH);
            racc = r && (mq.size() > 0);
            if (w && mq.size() == DEPTH) m_ovf = 1;
            if (r && mq.size() == 0) m_udf = 1;
            m_rv0 = racc;
            if (racc) begin
                head = mq.pop_front();
                q0.push_back(head);
                q1.push_back(head);
                m_rd0 = head;
            end
            if (wacc) mq.push_back(d);
        end
        @(posedge clk);
        #1;
        check_state();
        #1;
    endtask

    // Standard mode: a word appears with r_valid_o the cycle after its pop.
    always @(negedge clk) begin
        if (rv0 === 1'b1) begin
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_std_spurious actual=%0h required=none", rd0);
            end else begin
                chk("rd_std_data", 8'(rd0), 8'(q0.pop_front()));
            end
        end
    end

    // FWFT mode: the head word is consumed in the cycle r_inc_i is high.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && clr === 1'b0 && r_inc === 1'b1
            && rv1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_fwft_spurious actual=%0h required=none", rd1);
            end else begin
                chk("rd_fwft_data", 8'(rd1), 8'(q1.pop_front()));
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        clr    = 1'b0;
        w_inc  = 1'b0;
        r_inc  = 1'b0;
        w_data = '0;
        @(posedge clk);
        #2;

        step(0, 0, 1, 0, 4'h5);
        step(0, 0, 1, 0, 4'h6);

        for (int i = 1; i <= 4; i++) step(1, 0, 1, 0, 4'(i));
        step(1, 0, 1, 0, 4'h9);

        for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 4'h0);
        step(1, 0, 0, 0, 4'h0);

        step(1, 0, 1, 0, 4'h2);
        step(1, 0, 1, 0, 4'h3);
        for (int i = 0; i < 6; i++) step(1, 0, 1, 1, 4'(4'hA + i));

        step(1, 0, 1, 0, 4'h1);
        step(1, 0, 1, 0, 4'h8);
        step(1, 0, 1, 1, 4'h7);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 4'h0);

        step(1, 1, 0, 0, 4'h0);
        step(1, 0, 1, 0, 4'h5);
        step(1, 0, 0, 0, 4'h0);
        step(1, 0, 1, 1, 4'h6);
        step(1, 0, 1, 0, 4'h3);
        step(1, 1, 1, 1, 4'hE);
        step(1, 0, 0, 1, 4'h0);
        step(1, 1, 0, 0, 4'h0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 29) == 0,
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)));
        end

        step(1, 0, 0, 0, 4'h0);
        step(1, 0, 0, 0, 4'h0);
        chk("scoreboard_std_drained", 8'(q0.size()), 8'd0);
        chk("scoreboard_fwft_drained", 8'(q1.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
